// File: rtl/fft_peak_finder.sv
// Purpose: scans the FFT result RAM one bin per cycle, computes |X|^2 and keeps the two strongest bins.
// Latency: done pulses NSCAN+RD_LAT+3 cycles after start is sampled; peak outputs are valid with done.
// Backpressure: none; the RAM must return data RD_LAT cycles after each read, start is ignored while busy.
module fft_peak_finder #(
  parameter int ADDR_WIDTH    = 8,
  parameter int COMP_WIDTH    = 32,
  parameter int RD_LAT        = 1,
  parameter bit SKIP_DC       = 1'b1,
  parameter bit HALF_SPECTRUM = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    ram_ren,
  output logic [ADDR_WIDTH-1:0]   ram_raddr,
  input  logic [2*COMP_WIDTH-1:0] ram_rdata,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   peak_addr1,
  output logic [ADDR_WIDTH-1:0]   peak_addr2,
  output logic [2*COMP_WIDTH:0]   peak_mag1,
  output logic [2*COMP_WIDTH:0]   peak_mag2
);
  localparam int AW = ADDR_WIDTH;
  localparam int CW = COMP_WIDTH;
  localparam int DW = 2 * COMP_WIDTH;
  localparam int MW = 2 * COMP_WIDTH + 1;

  localparam logic [AW-1:0] FIRST = SKIP_DC ? AW'(1) : AW'(0);
  localparam logic [AW-1:0] LAST  = HALF_SPECTRUM ? AW'((1 << (AW - 1)) - 1) : {AW{1'b1}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_PUB   = 2'd3;

  logic [1:0]        state;
  logic [RD_LAT-1:0] rd_vld_sr;
  logic [AW-1:0]     rd_addr_sr [RD_LAT];
  logic              sq_vld;
  logic [AW-1:0]     sq_addr;
  logic [DW-1:0]     sq_re;
  logic [DW-1:0]     sq_im;
  logic              sum_vld;
  logic [AW-1:0]     sum_addr;
  logic [MW-1:0]     sum_mag;
  logic [MW-1:0]     wk_mag1;
  logic [MW-1:0]     wk_mag2;
  logic [AW-1:0]     wk_addr1;
  logic [AW-1:0]     wk_addr2;
  logic [MW-1:0]     nxt_mag1;
  logic [MW-1:0]     nxt_mag2;
  logic [AW-1:0]     nxt_addr1;
  logic [AW-1:0]     nxt_addr2;
  logic signed [DW-1:0] re_ext;
  logic signed [DW-1:0] im_ext;
  logic              pub_go;

  assign ram_ren = (state == S_SCAN);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_PUB);

  // The last scanned bin sits in the sum stage: its update and the publish happen on the same edge.
  assign pub_go = (state == S_DRAIN) && sum_vld && (sum_addr == LAST);

  // Control FSM and read address generator; the address holds once the scan is over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ram_raddr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_SCAN;
            ram_raddr <= FIRST;
          end
        end
        S_SCAN: begin
          if (ram_raddr == LAST) state <= S_DRAIN;
          else                   ram_raddr <= ram_raddr + AW'(1);
        end
        S_DRAIN: begin
          if (pub_go) state <= S_PUB;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Delay the read enable and bin address to line up with the RAM's read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_sr <= '0;
      for (int i = 0; i < RD_LAT; i++) rd_addr_sr[i] <= '0;
    end else begin
      rd_vld_sr[0]  <= ram_ren;
      rd_addr_sr[0] <= ram_raddr;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld_sr[i]  <= rd_vld_sr[i-1];
        rd_addr_sr[i] <= rd_addr_sr[i-1];
      end
    end
  end

  // Sign-extend to full product width so -2^(C-1) squares exactly without wrapping.
  assign re_ext = DW'($signed(ram_rdata[DW-1:CW]));
  assign im_ext = DW'($signed(ram_rdata[CW-1:0]));

  // Square and sum stages; the sum carries one extra bit so two maximal squares cannot overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_vld   <= 1'b0;
      sq_addr  <= '0;
      sq_re    <= '0;
      sq_im    <= '0;
      sum_vld  <= 1'b0;
      sum_addr <= '0;
      sum_mag  <= '0;
    end else begin
      sq_vld   <= rd_vld_sr[RD_LAT-1];
      sq_addr  <= rd_addr_sr[RD_LAT-1];
      sq_re    <= DW'(re_ext * re_ext);
      sq_im    <= DW'(im_ext * im_ext);
      sum_vld  <= sq_vld;
      sum_addr <= sq_addr;
      sum_mag  <= {1'b0, sq_re} + {1'b0, sq_im};
    end
  end

  // Top-2 update; strict compares keep the lower bin on equal magnitudes since bins arrive in order.
  always_comb begin
    nxt_mag1  = wk_mag1;
    nxt_mag2  = wk_mag2;
    nxt_addr1 = wk_addr1;
    nxt_addr2 = wk_addr2;
    if (sum_vld) begin
      if (sum_mag > wk_mag1) begin
        nxt_mag2  = wk_mag1;
        nxt_addr2 = wk_addr1;
        nxt_mag1  = sum_mag;
        nxt_addr1 = sum_addr;
      end else if (sum_mag > wk_mag2) begin
        nxt_mag2  = sum_mag;
        nxt_addr2 = sum_addr;
      end
    end
  end

  // Working peaks restart at (0, FIRST) on every accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wk_mag1  <= '0;
      wk_mag2  <= '0;
      wk_addr1 <= '0;
      wk_addr2 <= '0;
    end else if ((state == S_IDLE) && start) begin
      wk_mag1  <= '0;
      wk_mag2  <= '0;
      wk_addr1 <= FIRST;
      wk_addr2 <= FIRST;
    end else begin
      wk_mag1  <= nxt_mag1;
      wk_mag2  <= nxt_mag2;
      wk_addr1 <= nxt_addr1;
      wk_addr2 <= nxt_addr2;
    end
  end

  // Published results change only on entry to the done cycle and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_mag1  <= '0;
      peak_mag2  <= '0;
      peak_addr1 <= '0;
      peak_addr2 <= '0;
    end else if (pub_go) begin
      peak_mag1  <= nxt_mag1;
      peak_mag2  <= nxt_mag2;
      peak_addr1 <= nxt_addr1;
      peak_addr2 <= nxt_addr2;
    end
  end

endmodule

// File: tb/tb_fft_peak_finder.sv
// Bench for fft_peak_finder: four parameter sets share one spectrum RAM and one start/reset stream.
// Each set has its own RAM latency model and a per-cycle compare against a two-pass top-2 model.
// Directed frames pin the model with hand-computed values; random frames follow.
module tb_fft_peak_finder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  int          cyc = 0;
  int          start_cyc;
  bit          scan_on;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] mem [256];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int g, input string nm, input logic [64:0] act, input logic [64:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40)
        $display("FAIL cfg%0d %s at cycle %0d: got %0d, need %0d", g, nm, cyc, act, req);
    end
  endtask

  function automatic logic [63:0] w(input logic [31:0] re, input logic [31:0] im);
    return {re, im};
  endfunction

  function automatic logic [64:0] magf(input logic [63:0] x);
    longint re;
    longint im;
    re = longint'($signed(x[63:32]));
    im = longint'($signed(x[31:0]));
    return 65'(re * re) + 65'(im * im);
  endfunction

  // Two passes: earliest argmax, then earliest argmax of the rest; zero magnitude reports FIRST.
  task automatic model(input int first, input int last,
                       output logic [7:0] a1, output logic [64:0] m1,
                       output logic [7:0] a2, output logic [64:0] m2);
    m1 = '0; a1 = 8'(first);
    for (int b = first; b <= last; b++)
      if (magf(mem[b]) > m1) begin m1 = magf(mem[b]); a1 = 8'(b); end
    m2 = '0; a2 = 8'(first);
    for (int b = first; b <= last; b++)
      if (b != int'(a1) && magf(mem[b]) > m2) begin m2 = magf(mem[b]); a2 = 8'(b); end
  endtask

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int RL    = (g == 1) ? 3 : (g == 2) ? 2 : 1;
    localparam bit SK    = (g <= 1);
    localparam bit HF    = (g != 3);
    localparam int FIRST = SK ? 1 : 0;
    localparam int LAST  = HF ? 127 : 255;
    localparam int NS    = LAST - FIRST + 1;
    localparam int DN    = NS + RL + 3;

    logic        ren, busy, done;
    logic [7:0]  raddr, pa1, pa2;
    logic [63:0] rdata;
    logic [64:0] pm1, pm2;
    logic [63:0] pipe [RL];
    int          t;
    int          ren_cnt = 0;
    int          done_t = 0;
    logic        e_ren, e_busy, e_done;
    logic [7:0]  e_raddr, e_a1, e_a2;
    logic [64:0] e_m1, e_m2;

    fft_peak_finder #(.ADDR_WIDTH(8), .COMP_WIDTH(32), .RD_LAT(RL),
                      .SKIP_DC(SK), .HALF_SPECTRUM(HF)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .ram_ren(ren), .ram_raddr(raddr), .ram_rdata(rdata),
      .busy(busy), .done(done),
      .peak_addr1(pa1), .peak_addr2(pa2), .peak_mag1(pm1), .peak_mag2(pm2));

    // RAM with RL-cycle read latency; garbage is returned when no read was issued.
    always @(posedge clk) begin
      pipe[0] <= ren ? mem[raddr] : {$urandom, $urandom};
      for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign rdata = pipe[RL-1];

    // Timeline expectations relative to the accepted start, checked every cycle.
    always @(negedge clk) begin
      e_ren = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      if (!rst_n) begin
        t = -1;
        e_raddr = '0; e_a1 = '0; e_a2 = '0; e_m1 = '0; e_m2 = '0;
      end else begin
        t = scan_on ? cyc - start_cyc : -1;
        e_ren  = (t >= 1) && (t <= NS);
        e_busy = (t >= 1) && (t <= DN);
        e_done = (t == DN);
        if (e_ren) e_raddr = 8'(FIRST + t - 1);
        if (e_done) model(FIRST, LAST, e_a1, e_m1, e_a2, e_m2);
      end
      if (t == 0) ren_cnt = 0;
      if (ren) ren_cnt++;
      if (done) done_t = t;
      chk(g, "ram_ren", 65'(ren), 65'(e_ren));
      chk(g, "busy", 65'(busy), 65'(e_busy));
      chk(g, "done", 65'(done), 65'(e_done));
      chk(g, "ram_raddr", 65'(raddr), 65'(e_raddr));
      chk(g, "peak_addr1", 65'(pa1), 65'(e_a1));
      chk(g, "peak_addr2", 65'(pa2), 65'(e_a2));
      chk(g, "peak_mag1", pm1, e_m1);
      chk(g, "peak_mag2", pm2, e_m2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int b = 0; b < 256; b++) mem[b] = '0;
  endtask

  // One full scan; with poke, start is re-pulsed at cycles 50 and 131 and must be ignored.
  task automatic run_frame(input bit poke);
    int tt;
    start = 1'b1; start_cyc = cyc; scan_on = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 268; i++) begin
      tt = cyc - start_cyc;
      start = poke && (tt == 50 || tt == 131);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic fill_random();
    int mode;
    mode = int'($urandom_range(0, 2));
    for (int b = 0; b < 256; b++) begin
      case (mode)
        0: mem[b] = ($urandom_range(0, 9) == 0) ?
                    w(32'(int'($urandom_range(0, 10)) - 5), 32'(int'($urandom_range(0, 10)) - 5)) : 64'd0;
        1: mem[b] = {$urandom, $urandom};
        default: mem[b] = w(32'(int'($urandom_range(0, 2000)) - 1000),
                            32'(int'($urandom_range(0, 2000)) - 1000));
      endcase
    end
    if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 255)] = w(32'h8000_0000, 32'h8000_0000);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; scan_on = 1'b0; start_cyc = 0;
    clear_mem();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Two tones, with ignored start pulses mid-scan and in the publish cycle of cfg0.
    mem[10] = w(32'd100, 32'd0);
    mem[20] = w(32'd0, -32'sd200);
    run_frame(1'b1);
    chk(0, "tones_a1", 65'(cfg[0].pa1), 65'd20);
    chk(0, "tones_m1", cfg[0].pm1, 65'd40000);
    chk(0, "tones_a2", 65'(cfg[0].pa2), 65'd10);
    chk(0, "tones_m2", cfg[0].pm2, 65'd10000);
    chk(0, "ren_cycles", 65'(cfg[0].ren_cnt), 65'd127);
    chk(0, "done_cycle", 65'(cfg[0].done_t), 65'd131);
    chk(1, "done_cycle", 65'(cfg[1].done_t), 65'd133);
    chk(2, "ren_cycles", 65'(cfg[2].ren_cnt), 65'd128);
    chk(3, "ren_cycles", 65'(cfg[3].ren_cnt), 65'd256);
    chk(3, "done_cycle", 65'(cfg[3].done_t), 65'd260);

    // DC bin skipped or not.
    clear_mem();
    mem[0] = w(32'd1000, 32'd0);
    mem[3] = w(32'd3, 32'd4);
    run_frame(1'b0);
    chk(0, "dc_a1", 65'(cfg[0].pa1), 65'd3);
    chk(0, "dc_m1", cfg[0].pm1, 65'd25);
    chk(0, "dc_a2", 65'(cfg[0].pa2), 65'd1);
    chk(0, "dc_m2", cfg[0].pm2, 65'd0);
    chk(2, "dc_a1", 65'(cfg[2].pa1), 65'd0);
    chk(2, "dc_m1", cfg[2].pm1, 65'd1000000);
    chk(2, "dc_a2", 65'(cfg[2].pa2), 65'd3);

    // Equal magnitudes: lower bin first.
    clear_mem();
    mem[5] = w(32'd3, 32'd4);
    mem[9] = w(-32'sd4, 32'd3);
    run_frame(1'b0);
    chk(0, "tie_a1", 65'(cfg[0].pa1), 65'd5);
    chk(0, "tie_a2", 65'(cfg[0].pa2), 65'd9);
    chk(0, "tie_m2", cfg[0].pm2, 65'd25);

    mem[9] = w(32'd4, 32'd4);
    run_frame(1'b0);
    chk(0, "order_a1", 65'(cfg[0].pa1), 65'd9);
    chk(0, "order_m1", cfg[0].pm1, 65'd32);
    chk(0, "order_a2", 65'(cfg[0].pa2), 65'd5);

    // Most negative components.
    clear_mem();
    mem[7] = w(32'h8000_0000, 32'h8000_0000);
    run_frame(1'b0);
    chk(0, "ext_a1", 65'(cfg[0].pa1), 65'd7);
    chk(0, "ext_m1", cfg[0].pm1, 65'h8000_0000_0000_0000);

    // Bin 200 outside the half spectrum.
    clear_mem();
    mem[7]   = w(32'd3, 32'd4);
    mem[200] = w(32'd30000, 32'd0);
    run_frame(1'b0);
    chk(0, "half_a1", 65'(cfg[0].pa1), 65'd7);
    chk(3, "full_a1", 65'(cfg[3].pa1), 65'd200);
    chk(3, "full_m1", cfg[3].pm1, 65'd900000000);
    chk(3, "full_a2", 65'(cfg[3].pa2), 65'd7);

    // Reset at cycle 60 aborts everything; a later start completes normally.
    start = 1'b1; start_cyc = cyc; scan_on = 1'b1;
    tick();
    start = 1'b0;
    repeat (59) tick();
    rst_n = 1'b0; scan_on = 1'b0;
    tick();
    chk(0, "rst_busy", 65'(cfg[0].busy), 65'd0);
    chk(0, "rst_a1", 65'(cfg[0].pa1), 65'd0);
    chk(3, "rst_m1", cfg[3].pm1, 65'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    run_frame(1'b0);
    chk(3, "rerun_a1", 65'(cfg[3].pa1), 65'd200);
    chk(0, "rerun_m1", cfg[0].pm1, 65'd25);

    // Random spectra.
    for (int f = 0; f < 20; f++) begin
      fill_random();
      run_frame(f[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_peak_finder.md
Name: fft_peak_finder

Overview:
- Post-processing block for the FFT result RAM. After the FFT signals done, it scans the complex result buffer one bin per cycle and computes |X|^2 for each bin.
- Reports the two strongest bins, both address and magnitude.
- Parametrised successor of the fixed 256-point max1/max2 logic: generalised in depth, sample width and RAM read latency, with optional DC skip and half-spectrum scan.

Parameters:
- ADDR_WIDTH, 8, log2 of FFT length N; result RAM depth 2^ADDR_WIDTH.
- COMP_WIDTH, 32, width of each signed real/imag component.
- RD_LAT, 1, result RAM read latency in cycles, from ram_ren/ram_raddr to valid ram_rdata; legal range 1..3.
- SKIP_DC, 1, 1 = bin 0 excluded from the scan.
- HALF_SPECTRUM, 1, 1 = scan bins up to N/2-1 only (real-input symmetry); 0 = scan up to N-1.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle request to begin a scan.
- ram_ren, output, 1, result RAM read enable.
- ram_raddr, output, ADDR_WIDTH, result RAM read address.
- ram_rdata, input, 2*COMP_WIDTH, RAM word {real[2C-1:C], imag[C-1:0]}, two's complement.
- busy, output, 1, high from the cycle after start is accepted until done.
- done, output, 1, one-cycle pulse when results are published.
- peak_addr1, output, ADDR_WIDTH, bin of the largest magnitude.
- peak_addr2, output, ADDR_WIDTH, bin of the second largest magnitude.
- peak_mag1, output, 2*COMP_WIDTH+1, |X|^2 of peak_addr1.
- peak_mag2, output, 2*COMP_WIDTH+1, |X|^2 of peak_addr2.

Behaviour:
- Scan range:
  - FIRST = SKIP_DC ? 1 : 0.
  - LAST = HALF_SPECTRUM ? N/2-1 : N-1.
  - NSCAN = LAST-FIRST+1.
- Reset: all outputs 0, FSM to IDLE, pipeline valid bits cleared. Asserting rst_n low mid-scan aborts immediately; no done pulse follows. Published peak outputs return to 0.
- FSM:
  - IDLE: start=1 → clear working peaks (mag=0, addr=FIRST), go to SCAN.
  - SCAN: ram_ren=1, ram_raddr=FIRST..LAST incrementing one per cycle. After LAST is issued, go to DRAIN.
  - DRAIN: ram_ren=0; wait until the last bin leaves the pipeline, then go to PUB.
  - PUB: done=1 for one cycle; copy working peaks to the outputs; return to IDLE.
- start is ignored unless the FSM is in IDLE. start in the PUB cycle is also ignored.
- busy = (state != IDLE).
- ram_raddr holds its last value while ram_ren=0.
- Datapath pipeline, for an address issued in cycle k:
  - ram_rdata is valid at cycle k+RD_LAT.
  - Squares re^2 and im^2 are registered at k+RD_LAT+1; each is 2*COMP_WIDTH bits unsigned.
  - The sum is registered at k+RD_LAT+2; it is 2*COMP_WIDTH+1 bits and must never overflow.
  - The compare/update is visible at k+RD_LAT+3.
- Latency: start sampled at edge 0 → ram_ren high in cycles 1..NSCAN → done high in cycle NSCAN+RD_LAT+3.
- The bin address travels down the pipeline alongside the data, delayed by a matching shift register.
- Update rule, per valid bin with magnitude m:
  - If m > mag1: mag2←mag1, addr2←addr1, mag1←m, addr1←bin.
  - Else if m > mag2: mag2←m, addr2←bin.
  - Comparison is strict, so on equal magnitudes the lower bin index wins.
- All-zero spectrum: both addrs = FIRST, both mags = 0.
- Most negative component (-2^(C-1)) squares to 2^(2C-2) exactly, with no saturation.
- Published outputs change only in the PUB cycle and hold otherwise, including across subsequent busy periods.

Test Plan:
- Two tones (N=256, SKIP_DC=1, HALF=1, RD_LAT=1); RAM all zero except bin10=(100,0) and bin20=(0,-200). Required response:
  - ram_ren high for exactly 127 cycles, addresses 1..127.
  - done high in cycle 131.
  - peak_addr1=20, mag1=40000; peak_addr2=10, mag2=10000.
- DC skip: bin0=(1000,0), bin3=(3,4), rest zero. SKIP_DC=1 → addr1=3, mag1=25, addr2=1, mag2=0. SKIP_DC=0 → addr1=0, mag1=1000000, addr2=3; NSCAN=128.
- Tie and ordering:
  - bin5=(3,4), bin9=(-4,3), rest zero → addr1=5, addr2=9, both mags 25.
  - Same data with bin9=(4,4) instead → addr1=9 (mag 32), addr2=5 (mag 25).
- Extremes: bin7=(-2^31,-2^31), COMP_WIDTH=32 → mag1=2^63 exactly, addr1=7. Bin 200 loaded large with HALF=1 → ignored; with HALF=0 → found.
- Control:
  - start pulsed again at cycle 50 → no restart; done still in cycle 131.
  - rst_n low at cycle 60 → all outputs 0, busy=0, no done; a new start afterwards completes normally.
  - RD_LAT=3 → done in cycle 133.
- Regression: random spectra over 20 frames for each parameter set, checked against a reference top-2 model in the bench.
